// File: rtl/imm_gen_if.sv
// Handshake bundle for the immediate-generation stage: fetch-side push and
// decode-side pop. The stage uses the slave view; its driver uses master.
interface imm_gen_if #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_instr;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  out_imm;
    logic [2:0]       out_fmt;
    logic [TAG_W-1:0] out_tag;

    modport master (
        output in_valid, in_instr, in_tag, out_ready,
        input  in_ready, out_valid, out_imm, out_fmt, out_tag
    );

    modport slave (
        input  in_valid, in_instr, in_tag, out_ready,
        output in_ready, out_valid, out_imm, out_fmt, out_tag
    );
endinterface

// File: rtl/imm_gen_stage.sv
// Immediate decode + sign extension into a 2-entry elastic buffer.
// Optional macro IMM_GEN_ZIMM_EN: CSR*I instructions decode as zimm (fmt Z).
module imm_gen_stage #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 32
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      flush,
    imm_gen_if.slave  bus
);
    localparam logic [2:0] FMT_I = 3'd0;
    localparam logic [2:0] FMT_S = 3'd1;
    localparam logic [2:0] FMT_B = 3'd2;
    localparam logic [2:0] FMT_U = 3'd3;
    localparam logic [2:0] FMT_J = 3'd4;
`ifdef IMM_GEN_ZIMM_EN
    localparam logic [2:0] FMT_Z = 3'd5;
`endif
    localparam logic [2:0] FMT_R = 3'd6;

    typedef struct packed {
        logic [XLEN-1:0]  imm;
        logic [2:0]       fmt;
        logic [TAG_W-1:0] tag;
    } entry_t;

    logic [31:0] instr;
    logic [31:0] imm32;
    logic [2:0]  fmt;
    entry_t      d_in;
    entry_t      head, tail;
    logic [1:0]  count;
    logic        push, pop;

    assign instr = bus.in_instr;

    // All formats are built as 32-bit sign-correct values; zimm has bit 31
    // clear, so one sign extension to XLEN covers every case.
    always_comb begin
        imm32 = {{20{instr[31]}}, instr[31:20]};
        fmt   = FMT_I;
        case (instr[6:0])
            7'b0100011: begin
                imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
                fmt   = FMT_S;
            end
            7'b1100011: begin
                imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
                fmt   = FMT_B;
            end
            7'b0110111, 7'b0010111: begin
                imm32 = {instr[31:12], 12'b0};
                fmt   = FMT_U;
            end
            7'b1101111: begin
                imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
                fmt   = FMT_J;
            end
            7'b0110011, 7'b0111011: begin
                imm32 = 32'b0;
                fmt   = FMT_R;
            end
`ifdef IMM_GEN_ZIMM_EN
            7'b1110011: begin
                if (instr[14]) begin
                    imm32 = {27'b0, instr[19:15]};
                    fmt   = FMT_Z;
                end
            end
`endif
            default: ;
        endcase
    end

    always_comb begin
        d_in.imm = XLEN'($signed(imm32));
        d_in.fmt = fmt;
        d_in.tag = bus.in_tag;
    end

    assign bus.in_ready  = (count != 2'd2);
    assign bus.out_valid = (count != 2'd0);
    assign push = bus.in_valid && bus.in_ready;
    assign pop  = bus.out_valid && bus.out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head  <= '0;
            tail  <= '0;
            count <= 2'd0;
        end else if (flush) begin
            count <= 2'd0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (count == 2'd0) head <= d_in;
                    else               tail <= d_in;
                    count <= count + 2'd1;
                end
                2'b01: begin
                    head  <= tail;
                    count <= count - 2'd1;
                end
                // push+pop only possible at count 1: new word replaces head
                2'b11: head <= d_in;
                default: ;
            endcase
        end
    end

    assign bus.out_imm = head.imm;
    assign bus.out_fmt = head.fmt;
    assign bus.out_tag = head.tag;
endmodule

// File: tb/tb_imm_gen_stage.sv
// Bench for imm_gen_stage: XLEN=32 and XLEN=64 instances run in lockstep
// against a queue-based reference model with arithmetic immediate decode.
module tb_imm_gen_stage;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] in_instr = '0;
    logic [31:0] in_tag = '0;

    int n_chk = 0;
    int n_fail = 0;

    imm_gen_if #(.XLEN(32), .TAG_W(32)) b32 ();
    imm_gen_if #(.XLEN(64), .TAG_W(32)) b64 ();

    assign b32.in_valid  = in_valid;
    assign b32.in_instr  = in_instr;
    assign b32.in_tag    = in_tag;
    assign b32.out_ready = out_ready;
    assign b64.in_valid  = in_valid;
    assign b64.in_instr  = in_instr;
    assign b64.in_tag    = in_tag;
    assign b64.out_ready = out_ready;

    imm_gen_stage #(.XLEN(32), .TAG_W(32)) dut (.clk(clk), .rst_n(rst_n), .flush(flush), .bus(b32));
    imm_gen_stage #(.XLEN(64), .TAG_W(32)) dut64 (.clk(clk), .rst_n(rst_n), .flush(flush), .bus(b64));

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] imm;
        logic [2:0]  fmt;
        logic [31:0] tag;
    } exp_t;
    exp_t q[$];

    localparam longint P11 = longint'(1) << 11;
    localparam longint P12 = longint'(1) << 12;
    localparam longint P20 = longint'(1) << 20;
    localparam longint P31 = longint'(1) << 31;

    function automatic void ref_decode(input logic [31:0] i, output logic [63:0] imm, output logic [2:0] fmt);
        longint v;
        v = longint'(i[31:20]);
        if (v >= P11) v -= P12;
        fmt = 3'd0;
        case (i[6:0])
            7'h23: begin
                v = longint'(i[31:25]) * 32 + longint'(i[11:7]);
                if (v >= P11) v -= P12;
                fmt = 3'd1;
            end
            7'h63: begin
                v = longint'(i[31]) * 4096 + longint'(i[7]) * 2048 + longint'(i[30:25]) * 32 + longint'(i[11:8]) * 2;
                if (v >= P12) v -= 2 * P12;
                fmt = 3'd2;
            end
            7'h37, 7'h17: begin
                v = longint'(i[31:12]) * 4096;
                if (v >= P31) v -= 2 * P31;
                fmt = 3'd3;
            end
            7'h6F: begin
                v = longint'(i[31]) * P20 + longint'(i[19:12]) * 4096 + longint'(i[20]) * 2048 + longint'(i[30:21]) * 2;
                if (v >= P20) v -= 2 * P20;
                fmt = 3'd4;
            end
            7'h33, 7'h3B: begin
                v = 0;
                fmt = 3'd6;
            end
            default: ;
        endcase
`ifdef IMM_GEN_ZIMM_EN
        if (i[6:0] == 7'h73 && i[14]) begin
            v = longint'(i[19:15]);
            fmt = 3'd5;
        end
`endif
        imm = v;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [6:0] ops [10] = '{7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h33, 7'h3B, 7'h73, 7'h13, 7'h03};
        logic [31:0] r;
        r = $urandom;
        if ($urandom_range(0, 7) == 0) return r;
        return {r[31:7], ops[$urandom_range(0, 9)]};
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        n_chk++; if (b32.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", b32.out_valid); end
        n_chk++; if (b32.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", b32.in_ready); end
        n_chk++; if (b32.out_imm !== 32'h0 || b64.out_imm !== 64'h0) begin n_fail++; $display("FAIL reset_imm: got %h/%h want 0", b32.out_imm, b64.out_imm); end
        n_chk++; if (b32.out_fmt !== 3'd0 || b32.out_tag !== 32'h0) begin n_fail++; $display("FAIL reset_fmt_tag: got %h/%h want 0", b32.out_fmt, b32.out_tag); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_formats();
        logic [31:0] vi [8]  = '{32'hFE512E23, 32'h001000EF, 32'h80000537, 32'hFE000EE3,
                                 32'h00B50533, 32'hFFF00093, 32'h300FD073, 32'h12345017};
        logic [63:0] ve [8]  = '{64'hFFFFFFFFFFFFFFFC, 64'h800, 64'hFFFFFFFF80000000, 64'hFFFFFFFFFFFFFFFC,
                                 64'h0, 64'hFFFFFFFFFFFFFFFF,
`ifdef IMM_GEN_ZIMM_EN
                                 64'h1F,
`else
                                 64'h300,
`endif
                                 64'h12345000};
        logic [2:0]  vf [8]  = '{3'd1, 3'd4, 3'd3, 3'd2, 3'd6, 3'd0,
`ifdef IMM_GEN_ZIMM_EN
                                 3'd5,
`else
                                 3'd0,
`endif
                                 3'd3};
        out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            in_valid = 1'b1; in_instr = vi[k]; in_tag = 32'hA000 + k;
            @(negedge clk);
            in_valid = 1'b0;
            n_chk++; if (b32.out_valid !== 1'b1) begin n_fail++; $display("FAIL fmt%0d_valid: got %b want 1", k, b32.out_valid); end
            n_chk++; if (b32.out_imm !== ve[k][31:0]) begin n_fail++; $display("FAIL fmt%0d_imm32: got %h want %h", k, b32.out_imm, ve[k][31:0]); end
            n_chk++; if (b64.out_imm !== ve[k]) begin n_fail++; $display("FAIL fmt%0d_imm64: got %h want %h", k, b64.out_imm, ve[k]); end
            n_chk++; if (b32.out_fmt !== vf[k] || b64.out_fmt !== vf[k]) begin n_fail++; $display("FAIL fmt%0d_fmt: got %0d want %0d", k, b32.out_fmt, vf[k]); end
            n_chk++; if (b32.out_tag !== 32'hA000 + k) begin n_fail++; $display("FAIL fmt%0d_tag: got %h want %h", k, b32.out_tag, 32'hA000 + k); end
        end
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        logic [31:0] got[$];
        logic acc = 1'b0;
        out_ready = 1'b0;
        in_valid = 1'b1; in_instr = 32'h00000013; in_tag = 32'd1;
        @(negedge clk);
        n_chk++; if (b32.in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready_after1: got %b want 1", b32.in_ready); end
        in_tag = 32'd2;
        @(negedge clk);
        n_chk++; if (b32.in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready_after2: got %b want 0", b32.in_ready); end
        in_tag = 32'd3;
        repeat (2) @(negedge clk);
        n_chk++; if (b32.in_ready !== 1'b0 || b32.out_tag !== 32'd1) begin n_fail++; $display("FAIL bp_stall: got ready %b tag %0d want 0/1", b32.in_ready, b32.out_tag); end
        out_ready = 1'b1;
        for (int c = 0; c < 12; c++) begin
            if (acc) in_valid = 1'b0;
            if (in_valid && b32.in_ready) acc = 1'b1;
            if (b32.out_valid && out_ready) got.push_back(b32.out_tag);
            @(negedge clk);
            if (c == 0) begin
                n_chk++; if (b32.in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready_rise: got %b want 1", b32.in_ready); end
            end
        end
        n_chk++;
        if (got.size() != 3 || got[0] !== 32'd1 || got[1] !== 32'd2 || got[2] !== 32'd3) begin
            n_fail++; $display("FAIL bp_order: got %0d items %p want 1 2 3", got.size(), got);
        end
        n_chk++; if (b32.out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drained: got %b want 0", b32.out_valid); end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        in_valid = 1'b1; in_instr = 32'h00000013; in_tag = 32'd10;
        @(negedge clk); in_tag = 32'd11;
        @(negedge clk);
        n_chk++; if (b32.in_ready !== 1'b0) begin n_fail++; $display("FAIL flush_full: got %b want 0", b32.in_ready); end
        flush = 1'b1; in_tag = 32'd12;
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0;
        n_chk++; if (b32.out_valid !== 1'b0 || b32.in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_full_clear: got valid %b ready %b want 0/1", b32.out_valid, b32.in_ready); end
        @(negedge clk);
        n_chk++; if (b32.out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_push_absent: got %b want 0", b32.out_valid); end
        in_valid = 1'b1; in_tag = 32'd20;
        @(negedge clk);
        flush = 1'b1; out_ready = 1'b1; in_tag = 32'd21;
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        n_chk++; if (b32.out_valid !== 1'b0 || b64.out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_pushpop: got %b want 0", b32.out_valid); end
        @(negedge clk);
        n_chk++; if (b32.out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_pushpop_after: got %b want 0", b32.out_valid); end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        in_valid = 1'b1; in_instr = 32'hFFF00093; in_tag = 32'h55;
        @(negedge clk); in_tag = 32'h56;
        @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_chk++; if (b32.out_valid !== 1'b0 || b32.in_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_hs: got valid %b ready %b want 0/1", b32.out_valid, b32.in_ready); end
        n_chk++; if (b32.out_imm !== 32'h0 || b64.out_imm !== 64'h0 || b32.out_fmt !== 3'd0 || b32.out_tag !== 32'h0) begin
            n_fail++; $display("FAIL rstmid_data: got imm %h fmt %0d tag %h want 0", b64.out_imm, b32.out_fmt, b32.out_tag);
        end
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_chk++; if (b32.out_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_after: got %b want 0", b32.out_valid); end
    endtask

    task automatic test_random();
        exp_t e;
        logic do_push, do_pop;
        q.delete();
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            n_chk++; if (b32.out_valid !== (q.size() != 0)) begin n_fail++; $display("FAIL rnd_valid c%0d: got %b want %b", c, b32.out_valid, q.size() != 0); end
            n_chk++; if (b32.in_ready !== (q.size() != 2) || b64.in_ready !== b32.in_ready) begin n_fail++; $display("FAIL rnd_ready c%0d: got %b want %b", c, b32.in_ready, q.size() != 2); end
            if (q.size() != 0) begin
                n_chk++;
                if (b32.out_imm !== q[0].imm[31:0] || b64.out_imm !== q[0].imm || b32.out_fmt !== q[0].fmt
                    || b64.out_fmt !== q[0].fmt || b32.out_tag !== q[0].tag) begin
                    n_fail++;
                    $display("FAIL rnd_head c%0d: got imm %h fmt %0d tag %h want imm %h fmt %0d tag %h",
                             c, b64.out_imm, b32.out_fmt, b32.out_tag, q[0].imm, q[0].fmt, q[0].tag);
                end
            end
            in_valid  = ($urandom_range(0, 3) != 0);
            in_instr  = rand_instr();
            in_tag    = $urandom;
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 31) == 0);
            if (flush) q.delete();
            else begin
                do_push = in_valid && (q.size() != 2);
                do_pop  = out_ready && (q.size() != 0);
                if (do_pop) void'(q.pop_front());
                if (do_push) begin
                    ref_decode(in_instr, e.imm, e.fmt);
                    e.tag = in_tag;
                    q.push_back(e);
                end
            end
        end
        @(negedge clk);
        in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_formats();
        test_backpressure();
        test_flush();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1);
    end
endmodule

// File: doc/imm_gen_stage.md
# imm_gen_stage

Registered, parametrised immediate-generation stage for the RISC-V core. It decodes the immediate of every instruction format (I, S, B, U, J, and optionally CSR zimm), sign-extends it to XLEN and tags it with its format code. A two-entry elastic buffer with valid/ready handshakes on both sides sits between fetch and the decode/execute boundary, providing backpressure and flush support for the pipelined datapath.

## Interface
- XLEN, 32: datapath width; legal values 32 or 64.
- TAG_W, 32: width of the sideband tag (e.g. PC) carried alongside each instruction.

- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous flush; empties the buffer.
- in_valid  in  1  instruction presented.
- in_ready  out  1  stage can accept an instruction this cycle.
- in_instr  in  32  raw instruction word.
- in_tag  in  TAG_W  sideband, passed through unchanged.
- out_valid  out  1  head entry valid.
- out_ready  in  1  consumer accepts head entry.
- out_imm  out  XLEN  extended immediate of head entry.
- out_fmt  out  3  format: 0=I, 1=S, 2=B, 3=U, 4=J, 5=Z (zimm), 6=R (no immediate).
- out_tag  out  TAG_W  tag of head entry.

## Operation
- Format selected by instr[6:0]:
  - 0100011 → S: sext({instr[31:25], instr[11:7]}).
  - 1100011 → B: sext({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}).
  - 0110111, 0010111 → U: sext({instr[31:12], 12'b0}).
  - 1101111 → J: sext({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}).
  - 0110011, 0111011 → R: imm = 0.
  - All other opcodes → I: sext(instr[31:20]).
- sext always replicates instr[31] up to bit XLEN-1. For U-type at XLEN=64, bits 63:32 are copies of instr[31].
- Buffer: 2-entry FIFO; occupancy count 0..2.
- Push when in_valid && in_ready; pop when out_valid && out_ready.
- in_ready = (count != 2); out_valid = (count != 0).
- FIFO order is strictly preserved; head data is held stable while out_valid && !out_ready.
- Push and pop in the same cycle at count 1: count stays 1, new entry becomes head after the edge.
- At count 2 no push occurs, since in_ready = 0.
- flush: count → 0 at the next edge. It overrides any same-cycle push or pop, and the pushed instruction is discarded.
- Reset (asynchronous, any time, including mid-transfer):
  - count = 0, in_ready = 1, out_valid = 0.
  - out_imm = 0, out_fmt = 0, out_tag = 0.
  - All entry storage = 0.
- Format decode is computed before storage; outputs are driven directly from the head register with no combinational path from in_* to out_*.

## Timing
- Latency: an instruction accepted at edge k is visible on out_* with out_valid = 1 after edge k.
- Throughput: 1 instruction/cycle when out_ready is held high.
- in_ready is a function of registered count only; there is no combinational path from out_ready to in_ready.
- After a stall (count = 2), in_ready rises the cycle after the first pop.
- After flush at edge k: out_valid = 0 and in_ready = 1 from edge k.

## Configuration
- IMM_GEN_ZIMM_EN defined:
  - opcode 1110011 with instr[14] = 1 (CSRRWI/CSRRSI/CSRRCI) → fmt Z.
  - imm = zero-extended instr[19:15].
- IMM_GEN_ZIMM_EN undefined:
  - those instructions fall to the I-type rule, i.e. sext(instr[31:20]), fmt I.
  - fmt code 5 is never produced.

## Test plan
- S-type (XLEN=32): push 0xFE512E23 (sw x5,-4(x2)) with out_ready = 1 → next cycle out_imm = 0xFFFFFFFC, out_fmt = 1, out_tag echoed.
- J-type: push 0x001000EF (jal x1,+2048) → out_imm = 0x00000800, out_fmt = 4.
- XLEN=64 U-type: push 0x80000537 (lui x10,0x80000) → out_imm = 0xFFFFFFFF80000000, out_fmt = 3.
- Backpressure: out_ready = 0, offer tags 1, 2, 3 back-to-back:
  - tags 1 and 2 are accepted; in_ready = 0 after the second acceptance.
  - tag 3 is held at the input.
  - raise out_ready → outputs appear in order 1, 2, 3, with no loss or duplication.
- Flush and reset:
  - with count = 2, assert flush together with a push → next cycle out_valid = 0, in_ready = 1, pushed word absent.
  - repeat with rst_n pulsed low mid-cycle → all outputs 0 immediately.
- Zimm: push 0x300FD073 (csrrwi x0,mstatus,31):
  - with IMM_GEN_ZIMM_EN → out_imm = 0x1F, out_fmt = 5.
  - without → out_imm = 0x300, out_fmt = 0.
